// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared types and helpers for the iterative multiply/divide unit.
//   mdu_op_t    : 3-bit operation code driven by the decode stage
//   mdu_state_t : sequencer state (IDLE -> CALC -> FIX -> IDLE)
//   cnt_width() : width of the iteration counter for a given datapath width
// -----------------------------------------------------------------------------
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_NOP0  = 3'b110,
    OP_NOP1  = 3'b111
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } mdu_state_t;

  // Counter must hold the value WIDTH itself, hence the extra bit.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative MULT/MULTU/DIV/DIVU (one result bit per cycle) plus single-cycle
// MTHI/MTLO, owning the architectural HI/LO registers.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high; clears all state
//   start  : request, accepted only when busy=0
//   op     : mdu_op_t operation code
//   a, b   : rs / rt operands
//   cancel : synchronous abort of an in-flight operation (pipeline flush)
//   busy   : operation in flight (decoded from state)
//   done   : one-cycle pulse after HI/LO were written by a mul/div
//   hi, lo : HI/LO registers
// -----------------------------------------------------------------------------
module muldiv_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_width(WIDTH);

  mdu_state_t         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;      // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   m;        // multiplicand or divisor magnitude
  logic               is_div;
  logic               sa;
  logic               sb;
  logic               div_zero;

  // Request decode and operand magnitudes.
  logic               op_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = op_signed && a[WIDTH-1];
  assign b_neg     = op_signed && b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  assign busy = (state != ST_IDLE);

  // One shared WIDTH+1-bit adder/subtractor serves both iteration kinds.
  logic [WIDTH:0]     add_a;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] acc_next;

  // NOTE: every combinational output gets a default at the top of the block so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    add_a    = {1'b0, acc[2*WIDTH-1:WIDTH]};
    acc_next = acc;
    if (is_div) begin
      add_a = acc[2*WIDTH-1:WIDTH-1];   // partial remainder shifted left by one
    end
    add_sum = add_a + ({1'b0, m} ^ {(WIDTH+1){is_div}}) + {{WIDTH{1'b0}}, is_div};
    if (is_div) begin
      // Restoring step: keep the difference only if it did not go negative.
      if (add_sum[WIDTH]) begin
        acc_next = {acc[2*WIDTH-2:0], 1'b0};
      end else begin
        acc_next = {add_sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end else begin
      // Shift-add step: add multiplicand when the current multiplier bit is set.
      if (acc[0]) begin
        acc_next = {add_sum, acc[WIDTH-1:1]};
      end else begin
        acc_next = {1'b0, acc[2*WIDTH-1:1]};
      end
    end
  end

  // Sign correction applied while in FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  always_comb begin
    prod_fix = (sa ^ sb) ? -acc : acc;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      // Divide by zero yields an all-ones quotient left unnegated; negating the
      // remainder by sa reconstructs the original dividend in HI.
      fix_lo = ((sa ^ sb) && !div_zero) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      fix_hi = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      acc      <= '0;
      m        <= '0;
      is_div   <= 1'b0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !cancel) begin
            if (!op[2]) begin
              is_div   <= op[1];
              div_zero <= op[1] && (b == '0);
              sa       <= a_neg;
              sb       <= b_neg;
              acc      <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
              m        <= op[1] ? b_mag : a_mag;
              cnt      <= CW'(WIDTH);
              state    <= ST_CALC;
            end else if (op == OP_MTHI) begin
              hi <= a;
            end else if (op == OP_MTLO) begin
              lo <= a;
            end
          end
        end
        ST_CALC: begin
          if (cancel) begin
            state <= ST_IDLE;
          end else begin
            acc <= acc_next;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              state <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          if (!cancel) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Directed self-checking bench for muldiv_unit: a 32-bit instance covering
// mul/div results, HI/LO moves, busy-period handling, cancel and async reset,
// plus an 8-bit instance for the narrow-width case.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;

  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  logic        start8;
  logic [2:0]  op8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        cancel8;
  logic        busy8;
  logic        done8;
  logic [7:0]  hi8;
  logic [7:0]  lo8;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .cancel(cancel8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts cycles with busy high; bounded so a stuck unit still terminates.
  task automatic wait_idle(inout int cyc);
    while (busy && cyc < 100) begin
      cyc++;
      tick();
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int cyc = 0;
    issue(o, x, y);
    wait_idle(cyc);
    check({tag, " busy_cycles"}, 64'(cyc), 64'd33);
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    int  cyc;
    bit  saw_done;

    reset   = 1'b1;
    start   = 1'b0;
    op      = OP_NOP0;
    a       = '0;
    b       = '0;
    cancel  = 1'b0;
    start8  = 1'b0;
    op8     = OP_NOP0;
    a8      = '0;
    b8      = '0;
    cancel8 = 1'b0;

    #2;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    #10 reset = 1'b0;
    tick();

    // MULTU max*max, done lasts exactly one cycle.
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    tick();
    check("multu_max done_pulse", 64'(done), 64'd0);

    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    // Next start issued while done is high is accepted (back-to-back).
    run_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op("divu_zero", OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    run_op("div_neg_zero", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    tick();

    // MTLO when idle: visible next cycle, no busy.
    issue(OP_MTLO, 32'h1234, 32'h0);
    check("mtlo lo", 64'(lo), 64'h1234);
    check("mtlo busy", 64'(busy), 64'd0);
    tick();
    check("mtlo busy_later", 64'(busy), 64'd0);
    check("mtlo done", 64'(done), 64'd0);

    // MTHI and a second MULTU during a busy MULTU are both ignored.
    cyc = 0;
    issue(OP_MULTU, 32'd3, 32'd4);
    cyc++;
    op = OP_MTHI; a = 32'hDEAD; start = 1'b1;
    tick();
    cyc++;
    op = OP_MULTU; a = 32'd5; b = 32'd5;
    tick();
    start = 1'b0;
    wait_idle(cyc);
    check("busy_ign busy_cycles", 64'(cyc), 64'd33);
    check("busy_ign done", 64'(done), 64'd1);
    check("busy_ign hi", 64'(hi), 64'd0);
    check("busy_ign lo", 64'(lo), 64'd12);
    tick();
    check("busy_ign no_restart", 64'(busy), 64'd0);

    // Cancel on the 10th CALC cycle with HI/LO preloaded.
    issue(OP_MTHI, 32'hAAAA, 32'h0);
    issue(OP_MTLO, 32'h5555, 32'h0);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 9; i++) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel busy", 64'(busy), 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      saw_done |= done;
      tick();
    end
    check("cancel no_done", 64'(saw_done), 64'd0);
    check("cancel hi", 64'(hi), 64'hAAAA);
    check("cancel lo", 64'(lo), 64'h5555);

    // Cancel in IDLE drops a simultaneous MTLO.
    op = OP_MTLO; a = 32'hBEEF; start = 1'b1; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0;
    check("idle_cancel lo", 64'(lo), 64'h5555);

    // WIDTH=8 instance.
    op8 = OP_MULT; a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    cyc = 0;
    while (busy8 && cyc < 100) begin
      cyc++;
      tick();
    end
    check("w8 busy_cycles", 64'(cyc), 64'd9);
    check("w8 done", 64'(done8), 64'd1);
    check("w8 hi", 64'(hi8), 64'h40);
    check("w8 lo", 64'(lo8), 64'h00);
    tick();

    // Asynchronous reset in the middle of a DIV.
    issue(OP_DIV, 32'd100, 32'd7);
    for (int i = 0; i < 5; i++) tick();
    check("pre_reset busy", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("async_reset busy", 64'(busy), 64'd0);
    check("async_reset done", 64'(done), 64'd0);
    check("async_reset hi", 64'(hi), 64'd0);
    check("async_reset lo", 64'(lo), 64'd0);
    #2 reset = 1'b0;
    tick();
    check("post_reset busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
